mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rd_port_hold.sv | 31 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared widths and read-owner encoding for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PC   = 2'd1,
    OWN_LDST = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/rd_port_hold.sv
`default_nettype none
// ============================================================================
// Module   : rd_port_hold
// Purpose  : Per-port read data path: bypass during the response cycle,
//            otherwise present the last read data returned to this port.
// Revision : 1.0 - initial release
// ============================================================================
module rd_port_hold
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] i_mem_rddata,
  output logic [DATA_W-1:0] o_rddata
);

  logic [DATA_W-1:0] r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (sel) begin
      r_hold <= i_mem_rddata;
    end
  end

  assign o_rddata = sel ? i_mem_rddata : r_hold;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Fetch vs load/store arbiter for one single-ported 16-bit memory,
//            load/store priority with a fetch starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_pc_rd,
  output logic [DATA_W-1:0] o_pc_rddata,
  output logic              o_pc_waitrequest,
  input  logic [ADDR_W-1:0] i_ldst_addr,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  logic [DATA_W-1:0] i_ldst_wrdata,
  output logic [DATA_W-1:0] o_ldst_rddata,
  output logic              o_ldst_waitrequest,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata
);

  localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

  owner_t             r_owner;
  logic [c_cnt_w-1:0] r_starve_cnt;

  logic w_pc_req;
  logic w_ls_req;
  logic w_ls_rd;
  logic w_fetch_turn;
  logic w_grant_pc;
  logic w_grant_ls;

  assign w_pc_req     = i_pc_rd;
  assign w_ls_req     = i_ldst_rd | i_ldst_wr;
  // A combined read+write request is a plain store: no read response.
  assign w_ls_rd      = i_ldst_rd & ~i_ldst_wr;
  assign w_fetch_turn = (r_starve_cnt == c_starve_max);

  // No grants while reset is held, so nothing reaches memory during reset.
  assign w_grant_ls = ~reset & w_ls_req & ~(w_pc_req & w_fetch_turn);
  assign w_grant_pc = ~reset & w_pc_req & ~w_grant_ls;

  assign o_pc_waitrequest   = w_pc_req & ~w_grant_pc;
  assign o_ldst_waitrequest = w_ls_req & ~w_grant_ls;

  always_comb begin
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = '0;
    if (w_grant_pc) begin
      o_mem_addr = i_pc_addr;
      o_mem_rd   = 1'b1;
    end else if (w_grant_ls) begin
      o_mem_addr   = i_ldst_addr;
      o_mem_rd     = w_ls_rd;
      o_mem_wr     = i_ldst_wr;
      o_mem_wrdata = i_ldst_wrdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!w_pc_req || w_grant_pc) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_starve_max) begin
      r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else if (w_grant_pc) begin
      r_owner <= OWN_PC;
    end else if (w_grant_ls && w_ls_rd) begin
      r_owner <= OWN_LDST;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  rd_port_hold u_pc_hold (
    .clk          (clk),
    .reset        (reset),
    .sel          (r_owner == OWN_PC),
    .i_mem_rddata (i_mem_rddata),
    .o_rddata     (o_pc_rddata)
  );

  rd_port_hold u_ldst_hold (
    .clk          (clk),
    .reset        (reset),
    .sel          (r_owner == OWN_LDST),
    .i_mem_rddata (i_mem_rddata),
    .o_rddata     (o_ldst_rddata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a memory model and a
//            read-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 3;

  logic        clk;
  logic        reset;
  logic [15:0] i_pc_addr;
  logic        i_pc_rd;
  logic [15:0] o_pc_rddata;
  logic        o_pc_waitrequest;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;
  logic        o_ldst_waitrequest;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [15:0] o_mem_wrdata;
  logic [15:0] i_mem_rddata;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_pc_addr          (i_pc_addr),
    .i_pc_rd            (i_pc_rd),
    .o_pc_rddata        (o_pc_rddata),
    .o_pc_waitrequest   (o_pc_waitrequest),
    .i_ldst_addr        (i_ldst_addr),
    .i_ldst_rd          (i_ldst_rd),
    .i_ldst_wr          (i_ldst_wr),
    .i_ldst_wrdata      (i_ldst_wrdata),
    .o_ldst_rddata      (o_ldst_rddata),
    .o_ldst_waitrequest (o_ldst_waitrequest),
    .o_mem_addr         (o_mem_addr),
    .o_mem_rd           (o_mem_rd),
    .o_mem_wr           (o_mem_wr),
    .o_mem_wrdata       (o_mem_wrdata),
    .i_mem_rddata       (i_mem_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten locations return a fixed scramble of the address.
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 16'h5A3C);
  endfunction

  always @(posedge clk) begin
    if (o_mem_wr) mem[o_mem_addr] = o_mem_wrdata;
    i_mem_rddata <= o_mem_rd ? mem_read(o_mem_addr) : 16'hDEAD;
  end

  typedef struct {
    bit          to_pc;
    logic [15:0] data;
  } resp_t;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_starve = 0;
  logic [15:0] m_pc_hold = '0;
  logic [15:0] m_ls_hold = '0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cycle(input logic rst, input logic pc_rd, input logic [15:0] pc_addr,
                       input logic ls_rd, input logic ls_wr, input logic [15:0] ls_addr,
                       input logic [15:0] wd);
    logic        pc_req, ls_req, g_pc, g_ls;
    logic [15:0] d_pc, d_ls, e_addr, e_wd;
    logic        e_rd, e_wr;
    resp_t       resp;
    reset         = rst;
    i_pc_rd       = pc_rd;
    i_pc_addr     = pc_addr;
    i_ldst_rd     = ls_rd;
    i_ldst_wr     = ls_wr;
    i_ldst_addr   = ls_addr;
    i_ldst_wrdata = wd;
    @(negedge clk);
    pc_req = pc_rd;
    ls_req = ls_rd | ls_wr;
    g_ls   = !rst && ls_req && !(pc_req && m_starve == STARVE_LIMIT);
    g_pc   = !rst && pc_req && !g_ls;
    if (rst) begin
      m_pc_hold = '0;
      m_ls_hold = '0;
      sb.delete();
    end
    d_pc = m_pc_hold;
    d_ls = m_ls_hold;
    if (sb.size() > 0) begin
      resp = sb.pop_front();
      if (resp.to_pc) d_pc = resp.data;
      else            d_ls = resp.data;
    end
    check_eq("pc_rddata", o_pc_rddata, d_pc);
    check_eq("ldst_rddata", o_ldst_rddata, d_ls);
    check_eq("pc_waitrequest", {15'd0, o_pc_waitrequest}, {15'd0, pc_req & ~g_pc});
    check_eq("ldst_waitrequest", {15'd0, o_ldst_waitrequest}, {15'd0, ls_req & ~g_ls});
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0;
    if (g_pc) begin
      e_addr = pc_addr;
      e_rd   = 1'b1;
    end else if (g_ls) begin
      e_addr = ls_addr;
      e_rd   = ls_rd & ~ls_wr;
      e_wr   = ls_wr;
      e_wd   = wd;
    end
    check_eq("mem_addr", o_mem_addr, e_addr);
    check_eq("mem_rd", {15'd0, o_mem_rd}, {15'd0, e_rd});
    check_eq("mem_wr", {15'd0, o_mem_wr}, {15'd0, e_wr});
    check_eq("mem_wrdata", o_mem_wrdata, e_wd);
    if (g_pc) sb.push_back('{1'b1, mem_read(pc_addr)});
    else if (g_ls && e_rd) sb.push_back('{1'b0, mem_read(ls_addr)});
    m_pc_hold = d_pc;
    m_ls_hold = d_ls;
    if (rst || !pc_req || g_pc) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[16'h0010] = 16'hA5A5;
    mem[16'h8000] = 16'h0BAD;
    reset = 1'b1; i_pc_rd = 1'b0; i_pc_addr = '0; i_ldst_rd = 1'b0;
    i_ldst_wr = 1'b0; i_ldst_addr = '0; i_ldst_wrdata = '0;
    // reset state with requests pending: waitrequest follows request
    cycle(1, 1, 16'h0100, 1, 0, 16'h0200, 16'h0);
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // fetch only, response then hold
    cycle(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // simultaneous fetch and load
    cycle(0, 1, 16'h0020, 1, 0, 16'h8000, 16'h0);
    cycle(0, 1, 16'h0020, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // continuous contention: L L L F repeating
    for (int i = 0; i < 9; i++) cycle(0, 1, 16'h0030, 1, 0, 16'h8004, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // store then read it back
    cycle(0, 0, 16'h0000, 0, 1, 16'h9000, 16'h1234);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 1, 0, 16'h9000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // rd+wr together behaves as a store
    cycle(0, 0, 16'h0000, 1, 1, 16'h9002, 16'h5555);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    cycle(0, 1, 16'h9002, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // reset during an in-flight fetch response
    cycle(0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0);
    cycle(1, 1, 16'h0044, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    // mixed traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1'($urandom_range(0, 1)), 16'h0010 + 16'($urandom_range(0, 3) * 2),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            16'h9000 + 16'($urandom_range(0, 3) * 2), 16'($urandom));
    end
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
